// File: rtl/obi_sram_bridge_pkg.sv
// ============================================================================
// Package : obi_sram_bridge_pkg
// Purpose : Shared types and constants for obi_sram_bridge:
//           - default OBI request/response structs,
//           - FSM state enum,
//           - response-kind enum,
//           - read-data pattern returned for out-of-range reads.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_sram_bridge_pkg;

    // Default OBI request: strobe, write enable, byte enables, byte address, write data.
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_default_t;

    // Default OBI response: grant, read-valid, read data.
    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_default_t;

    // Bridge FSM. ST_WAIT is only reachable when wait states are compiled in.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // What the response beat following a grant has to return.
    typedef enum logic [1:0] {
        RK_WRITE    = 2'd0,
        RK_READ     = 2'd1,
        RK_READ_ERR = 2'd2
    } resp_kind_e;

    // Read data returned for reads that miss the SRAM window.
    localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

    // Width of the wait-state counter / wait_cycles_i port.
    localparam int unsigned WAIT_W = 4;

endpackage : obi_sram_bridge_pkg

`default_nettype wire

// File: rtl/obi_sram_bridge.sv
// ============================================================================
// Module  : obi_sram_bridge
// Purpose : Bridges one OBI slave port onto a single-port synchronous SRAM
//           (one-cycle read latency). At most one transaction is outstanding.
//           Accesses outside [BaseAddr, BaseAddr + 4*NumWords) are granted
//           but never reach the SRAM; they are counted in err_cnt_o and reads
//           return 32'hBADCAB1E.
//
// Optional feature: define OBI_SRAM_BRIDGE_WAIT_EN to add the wait_cycles_i
//           port. A request arriving with wait_cycles_i = N > 0 is then
//           granted N cycles after it is first seen (if still asserted).
//
// Ports   :
//   clk_i          in   1              clock
//   rst_ni         in   1              asynchronous active-low reset
//   slave_req_i    in   obi_req_t      OBI request (req, we, be, addr, wdata)
//   slave_resp_o   out  obi_resp_t     OBI response (gnt, rvalid, rdata)
//   mem_req_o      out  1              SRAM access strobe
//   mem_we_o       out  1              SRAM write enable
//   mem_be_o       out  4              SRAM byte enables
//   mem_addr_o     out  clog2(NumWords) SRAM word index
//   mem_wdata_o    out  32             SRAM write data
//   mem_rdata_i    in   32             SRAM read data (one cycle after mem_req_o)
//   err_cnt_o      out  16             saturating out-of-range access count
//   wait_cycles_i  in   4              wait states (OBI_SRAM_BRIDGE_WAIT_EN only)
//
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_sram_bridge
    import obi_sram_bridge_pkg::*;
#(
    // The default request/response types are the package structs so that the
    // field accesses below are always legal; any struct with the same field
    // names may be substituted.
    parameter type         obi_req_t  = obi_req_default_t,
    parameter type         obi_resp_t = obi_resp_default_t,
    parameter int unsigned NumWords   = 1024,
    parameter logic [31:0] BaseAddr   = 32'h0,
    localparam int unsigned AW        = $clog2(NumWords)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  obi_req_t          slave_req_i,
    output obi_resp_t         slave_resp_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [15:0]       err_cnt_o
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
    ,
    input  logic [WAIT_W-1:0] wait_cycles_i
`endif
);

    state_e      state, state_nxt;
    resp_kind_e  kind, kind_nxt;
    logic [15:0] err_cnt;
    logic        gnt;
    logic        in_range;
    logic        mem_access;
    logic [AW-1:0] word_idx;

    // Range check in 33 bits so a window ending at 4 GiB does not wrap.
    logic [32:0] addr_ext;
    logic [32:0] lo_ext;
    logic [32:0] hi_ext;

    assign addr_ext = {1'b0, slave_req_i.addr};
    assign lo_ext   = {1'b0, BaseAddr};
    assign hi_ext   = lo_ext + (33'(NumWords) << 2);
    assign in_range = (addr_ext >= lo_ext) && (addr_ext < hi_ext);

    // Byte offset into the window, as a word index; addr[1:0] drop out here.
    assign word_idx = AW'((slave_req_i.addr - BaseAddr) >> 2);

`ifdef OBI_SRAM_BRIDGE_WAIT_EN
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            kind    <= RK_WRITE;
            err_cnt <= 16'h0000;
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
            wait_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            kind  <= kind_nxt;
            if (gnt && !in_range && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
            wait_cnt <= wait_cnt_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state and grant
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        gnt       = 1'b0;
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
        wait_cnt_nxt = wait_cnt;
`endif

        case (state)
            ST_IDLE, ST_RESP: begin
                // The response beat (if any) completes this cycle, so unless
                // something new is granted or delayed we fall back to idle.
                state_nxt = ST_IDLE;
                if (slave_req_i.req) begin
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
                    if (wait_cycles_i != '0) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = wait_cycles_i;
                    end else begin
                        gnt = 1'b1;
                    end
`else
                    gnt = 1'b1;
`endif
                end
            end
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
            ST_WAIT: begin
                if (!slave_req_i.req) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt <= WAIT_W'(1)) begin
                    // Counter loaded with N on entry: the last count lands
                    // exactly N cycles after the request was first seen.
                    gnt          = 1'b1;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // No grant may escape while reset is asserted, even though req is
        // sampled combinationally.
        if (!rst_ni) begin
            gnt = 1'b0;
        end

        if (gnt) begin
            state_nxt = ST_RESP;
            if (slave_req_i.we) begin
                kind_nxt = RK_WRITE;
            end else if (in_range) begin
                kind_nxt = RK_READ;
            end else begin
                kind_nxt = RK_READ_ERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // SRAM side: only an in-range grant touches the memory; otherwise every
    // mem_* output is parked at zero.
    // ------------------------------------------------------------------
    assign mem_access  = gnt && in_range;
    assign mem_req_o   = mem_access;
    assign mem_we_o    = mem_access ? slave_req_i.we    : 1'b0;
    assign mem_be_o    = mem_access ? slave_req_i.be    : 4'h0;
    assign mem_addr_o  = mem_access ? word_idx          : '0;
    assign mem_wdata_o = mem_access ? slave_req_i.wdata : 32'h0;

    // ------------------------------------------------------------------
    // OBI response. rvalid is simply "in RESP"; read data is passed straight
    // through from the SRAM, which presents it in this same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        slave_resp_o        = '0;
        slave_resp_o.gnt    = gnt;
        slave_resp_o.rvalid = (state == ST_RESP);
        if (state == ST_RESP) begin
            case (kind)
                RK_READ:     slave_resp_o.rdata = mem_rdata_i;
                RK_READ_ERR: slave_resp_o.rdata = ERR_RDATA;
                default:     slave_resp_o.rdata = 32'h0;
            endcase
        end
    end

    assign err_cnt_o = err_cnt;

endmodule : obi_sram_bridge

`default_nettype wire

// File: tb/tb_obi_sram_bridge.sv
// ============================================================================
// Module  : tb_obi_sram_bridge
// Purpose : Self-checking bench for obi_sram_bridge. Directed scenarios plus
//           a randomized transaction stream compared against a word-array
//           reference model of the SRAM window and error counter. Wait-state
//           scenarios are included when OBI_SRAM_BRIDGE_WAIT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_obi_sram_bridge;
    import obi_sram_bridge_pkg::*;

    localparam int unsigned NW   = 64;
    localparam int unsigned AW   = $clog2(NW);
    localparam logic [31:0] BASE = 32'h0000_4000;

    logic              clk = 1'b0;
    logic              rst_ni;
    obi_req_default_t  req;
    obi_resp_default_t resp;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
    logic [15:0]       err_cnt;
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
    logic [3:0]        wait_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obi_sram_bridge #(
        .obi_req_t  (obi_req_default_t),
        .obi_resp_t (obi_resp_default_t),
        .NumWords   (NW),
        .BaseAddr   (BASE)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .slave_req_i   (req),
        .slave_resp_o  (resp),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_be_o      (mem_be),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .err_cnt_o     (err_cnt)
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
        ,
        .wait_cycles_i (wait_cycles)
`endif
    );

    // ------------------------------------------------------------------
    // Bench SRAM (environment) and reference model
    // ------------------------------------------------------------------
    logic [31:0] sram    [NW];
    logic [31:0] ref_mem [NW];
    int          ref_err = 0;

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) sram[mem_addr] <= merge(sram[mem_addr], mem_wdata, mem_be);
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    function automatic bit ref_in_range(logic [31:0] a);
        longint unsigned x = longint'(a);
        return (x >= longint'(BASE)) && (x < longint'(BASE) + 4 * longint'(NW));
    endfunction

    function automatic int ref_idx(logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One granted transfer with zero wait states. Called at posedge+1 with
    // the bridge in IDLE or RESP; returns at posedge+1 in the RESP cycle with
    // req dropped, so the caller may chain another xfer immediately.
    task automatic xfer(input bit we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd);
        bit          ok  = ref_in_range(addr);
        int          idx = ok ? ref_idx(addr) : 0;
        logic [31:0] exp_rd;
        req.req = 1'b1; req.we = we; req.be = be; req.addr = addr; req.wdata = wdata;
        #2;
        check("gnt", {31'b0, resp.gnt}, 32'd1);
        check("mem_req", {31'b0, mem_req}, {31'b0, ok});
        if (ok) begin
            check("mem_addr", {26'b0, mem_addr}, idx);
            check("mem_we", {31'b0, mem_we}, {31'b0, we});
            check("mem_be", {28'b0, mem_be}, {28'b0, be});
            if (we) check("mem_wdata", mem_wdata, wdata);
        end else begin
            ref_err = (ref_err < 65535) ? ref_err + 1 : 65535;
        end
        if (we)      exp_rd = 32'h0;
        else if (ok) exp_rd = ref_mem[idx];
        else         exp_rd = 32'hBADCAB1E;
        if (we && ok) ref_mem[idx] = merge(ref_mem[idx], wdata, be);
        @(posedge clk); #1;
        req.req = 1'b0;
        check("rvalid", {31'b0, resp.rvalid}, 32'd1);
        check("rdata", resp.rdata, exp_rd);
        check("err_cnt", {16'b0, err_cnt}, ref_err);
        rd = resp.rdata;
    endtask

    task automatic idle_cycle();
        req = '0;
        #2;
        check("idle_gnt", {31'b0, resp.gnt}, 32'd0);
        check("idle_mem_req", {31'b0, mem_req}, 32'd0);
        check("idle_mem_addr", {26'b0, mem_addr}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] v;
        logic [31:0] a;

        for (int i = 0; i < NW; i++) begin
            v = $urandom;
            sram[i]    = v;
            ref_mem[i] = v;
        end

        // Reset with a live request: nothing may be granted.
        rst_ni = 1'b0;
        req = '0; req.req = 1'b1; req.addr = BASE + 32'd4;
`ifdef OBI_SRAM_BRIDGE_WAIT_EN
        wait_cycles = 4'd0;
`endif
        #2;
        check("rst_gnt", {31'b0, resp.gnt}, 32'd0);
        check("rst_rvalid", {31'b0, resp.rvalid}, 32'd0);
        check("rst_rdata", resp.rdata, 32'd0);
        check("rst_err", {16'b0, err_cnt}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        req = '0;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // Write then read BaseAddr+8 (word 2).
        xfer(1'b1, 4'hF, BASE + 32'd8, 32'hDEADBEEF, rd);
        idle_cycle();
        xfer(1'b0, 4'hF, BASE + 32'd8, 32'h0, rd);
        check("w2_readback", rd, 32'hDEADBEEF);
        idle_cycle();

        // Back-to-back reads of words 0..3.
        for (int w = 0; w < 4; w++) xfer(1'b0, 4'hF, BASE + 32'(4 * w), 32'h0, rd);
        idle_cycle();

        // Just past the top of the window.
        xfer(1'b0, 4'hF, BASE + 32'(4 * NW), 32'h0, rd);
        check("oor_err1", {16'b0, err_cnt}, 32'd1);
        idle_cycle();

        // Saturation: hold an out-of-range read (below the window) for 65534
        // more grants -> 65535, then a few more must not wrap.
        req = '0; req.req = 1'b1; req.addr = BASE - 32'd4;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_ffff", {16'b0, err_cnt}, 32'h0000FFFF);
        check("sat_rdata", resp.rdata, 32'hBADCAB1E);
        repeat (5) @(posedge clk);
        #1;
        check("sat_hold", {16'b0, err_cnt}, 32'h0000FFFF);
        ref_err = 65535;
        idle_cycle();

        // Reset in the cycle after a grant: response must vanish for good.
        req = '0; req.req = 1'b1; req.addr = BASE + 32'd12;
        #2;
        check("pre_rst_gnt", {31'b0, resp.gnt}, 32'd1);
        @(posedge clk); #1;
        req = '0;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_rvalid", {31'b0, resp.rvalid}, 32'd0);
        check("mid_rst_err", {16'b0, err_cnt}, 32'd0);
        check("mid_rst_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        @(posedge clk); #1;
        rst_ni = 1'b1;
        ref_err = 0;
        @(posedge clk); #1;
        check("post_rst_rvalid", {31'b0, resp.rvalid}, 32'd0);

        // Memcopy-style: read word 5, write the data to word 9.
        xfer(1'b1, 4'hF, BASE + 32'd20, 32'h1234_5678, rd);
        idle_cycle();
        xfer(1'b0, 4'hF, BASE + 32'd20, 32'h0, rd);
        idle_cycle();
        xfer(1'b1, 4'hF, BASE + 32'd36, rd, rd);
        idle_cycle();
        check("copy_sram9", sram[9], 32'h1234_5678);
        xfer(1'b0, 4'hF, BASE + 32'd36, 32'h0, rd);
        idle_cycle();

        // Randomized stream against the reference model.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 8)) + 32'($urandom_range(0, 3));
                1:       a = BASE + 32'(4 * NW) + 32'($urandom_range(0, 31));
                default: a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
            endcase
            xfer(1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, rd);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

`ifdef OBI_SRAM_BRIDGE_WAIT_EN
        // Three wait states: grant exactly 3 cycles after req rises; the
        // port is latched only on WAIT entry.
        wait_cycles = 4'd3;
        req = '0; req.req = 1'b1; req.addr = BASE + 32'd12;
        #2;
        check("ws_gnt0", {31'b0, resp.gnt}, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            wait_cycles = 4'd7;
            #1;
            check("ws_gnt", {31'b0, resp.gnt}, (k == 3) ? 32'd1 : 32'd0);
            check("ws_mem_req", {31'b0, mem_req}, (k == 3) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;
        req = '0;
        check("ws_rvalid", {31'b0, resp.rvalid}, 32'd1);
        check("ws_rdata", resp.rdata, ref_mem[3]);
        wait_cycles = 4'd0;
        idle_cycle();

        // Request withdrawn after one cycle: never granted, never reaches SRAM.
        wait_cycles = 4'd3;
        req = '0; req.req = 1'b1; req.addr = BASE + 32'd16;
        #2;
        check("wd_gnt0", {31'b0, resp.gnt}, 32'd0);
        @(posedge clk); #1;
        req = '0;
        for (int k = 0; k < 4; k++) begin
            #2;
            check("wd_gnt", {31'b0, resp.gnt}, 32'd0);
            check("wd_mem_req", {31'b0, mem_req}, 32'd0);
            check("wd_rvalid", {31'b0, resp.rvalid}, 32'd0);
            @(posedge clk); #1;
        end
        check("wd_state", {30'b0, dut.state}, {30'b0, ST_IDLE});
        wait_cycles = 4'd0;
        idle_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_obi_sram_bridge

`default_nettype wire

// File: doc/obi_sram_bridge.md
OBI_SRAM_BRIDGE -- requirements
Module: obi_sram_bridge

Interface
REQ-001 SHALL have parameter obi_req_t, default logic: OBI request struct (req, we, be, addr, wdata).
REQ-002 SHALL have parameter obi_resp_t, default logic: OBI response struct (gnt, rvalid, rdata).
REQ-003 SHALL have parameter NumWords, default 1024: SRAM depth in 32-bit words, power of two, at least 2.
REQ-004 SHALL have parameter BaseAddr, default 32'h0: byte address of word 0, aligned to 4*NumWords.
REQ-005 SHALL use one clock and an asynchronous active-low reset, named clk_i and rst_ni; the ports are:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- slave_req_i  input  obi_req_t  OBI request from an upstream master (e.g. the memcopy peripheral master port)
- slave_resp_o  output  obi_resp_t  OBI response to that master
- mem_req_o  output  1  SRAM access strobe
- mem_we_o  output  1  SRAM write enable
- mem_be_o  output  4  SRAM byte enables
- mem_addr_o  output  $clog2(NumWords)  SRAM word index
- mem_wdata_o  output  32  SRAM write data
- mem_rdata_i  input  32  SRAM read data, valid one cycle after mem_req_o
- err_cnt_o  output  16  count of out-of-range accesses
- wait_cycles_i  input  4  wait states per request; present only with OBI_SRAM_BRIDGE_WAIT_EN

Function
REQ-006 SHALL hold at most one outstanding transaction; FSM states: IDLE, WAIT (macro builds only), RESP.
REQ-007 SHALL compute the word index as (addr - BaseAddr) >> 2, using the low $clog2(NumWords) bits; addr[1:0] ignored.
REQ-008 SHALL treat an address as in range iff BaseAddr <= addr < BaseAddr + 4*NumWords, evaluated without 32-bit wrap-around.
REQ-009 SHALL assert gnt combinationally in the same cycle as req when in IDLE or RESP with zero pending wait states.
REQ-010 SHALL, on an in-range grant, drive mem_req_o=1 and mem_we_o/mem_be_o/mem_wdata_o from the request in that same cycle.
REQ-011 SHALL, on an out-of-range grant, keep mem_req_o=0 and increment err_cnt_o, saturating at 16'hFFFF.
REQ-012 SHALL move to RESP after any grant and assert rvalid for exactly one cycle, the cycle after gnt.
REQ-013 SHALL return rdata = mem_rdata_i for an in-range read, 32'hBADCAB1E for an out-of-range read, and 32'h0 for any write.
REQ-014 SHALL, from RESP, return to IDLE if no new request is granted; a new grant in RESP re-enters RESP, giving 1 transfer per cycle.
REQ-015 SHALL drive mem_req_o, mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o to 0 whenever no grant occurs.

Reset
REQ-016 SHALL, while rst_ni=0, force state IDLE, gnt=0, rvalid=0, rdata=0, err_cnt_o=0, all mem_* outputs 0 and the wait counter 0.
REQ-017 SHALL, on reset mid-transaction, drop the pending rvalid and not replay it after reset.

Configuration
REQ-018 SHALL, with OBI_SRAM_BRIDGE_WAIT_EN defined: on a new req seen in IDLE/RESP with wait_cycles_i=N>0, enter WAIT, load N, and withhold gnt.
REQ-019 SHALL, in WAIT, decrement the counter once per cycle and assert gnt when the counter reaches 0 and req is still high (N cycles after req).
REQ-020 SHALL, with the macro defined, return to IDLE without a grant if req drops in WAIT, and latch wait_cycles_i only at WAIT entry.
REQ-021 SHALL, with OBI_SRAM_BRIDGE_WAIT_EN undefined, omit the wait_cycles_i port and the WAIT state; behaviour equals N=0.

Structure
REQ-022 SHALL define the FSM state enum and the BADCAB1E error-data constant in package obi_sram_bridge_pkg.
REQ-023 SHALL be a single module with no sub-modules; address decode stays inline.

Verification
REQ-024 The bench SHALL check: write 32'hDEADBEEF to BaseAddr+8, then read it -> mem_addr_o=2, gnt in the req cycle, rvalid next cycle, rdata=32'hDEADBEEF.
REQ-025 The bench SHALL check: back-to-back reads of words 0..3 with req held -> 4 gnts and 4 rvalids on consecutive cycles, data in order.
REQ-026 The bench SHALL check: read of BaseAddr+4*NumWords -> mem_req_o=0, rdata=32'hBADCAB1E, err_cnt_o=1; 65536 bad accesses -> err_cnt_o=16'hFFFF.
REQ-027 The bench SHALL check: rst_ni low in the cycle after gnt -> no rvalid, err_cnt_o=0, state IDLE.
REQ-028 The bench SHALL check: with the macro, wait_cycles_i=3 -> gnt 3 cycles after req rises; req dropped after 1 cycle -> no gnt and no mem_req_o.
REQ-029 The bench SHALL check: memcopy-style sequence, read word 5, wait for rvalid, write word 9 -> SRAM word 9 equals word 5.
